bit_index_sequencer: RTL and testbench

Serialises a DATA_WIDTH-bit bitmap into a stream of set-bit indices, lowest index first, one index per accepted output beat. It sits between a producer of request/occupancy bitmaps and a consumer that services one index at a time, e.g. a scheduler draining pending-request masks. Each beat's index comes from a trailing-zero count of the remaining mask, and the emitted bit is then cleared. Both sides use valid/ready handshakes; back-to-back words stream with no bubble.

---
 rtl/bit_index_sequencer_pkg.sv | 10 +
 rtl/bit_index_sequencer_tz_count.sv | 22 ++
 rtl/bit_index_sequencer.sv | 93 +++++++++
 tb/tb_bit_index_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bit_index_sequencer_pkg.sv
// Shared types for the bit-index sequencer.
//   seq_state_t : IDLE (waiting for a word) / EMIT (draining a word)
package bit_index_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_t;

endpackage : bit_index_sequencer_pkg

// File: rtl/bit_index_sequencer_tz_count.sv
// Purely combinational trailing-zero counter.
//   i_data  [DATA_WIDTH-1:0]       : word to scan
//   o_count [$clog2(DATA_WIDTH):0] : index of lowest set bit, DATA_WIDTH when i_data == 0
module tz_count #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [$clog2(DATA_WIDTH):0]   o_count
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: a default before any conditional write keeps this combinational; without it a latch is inferred.
    o_count = CW'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (i_data[i]) o_count = CW'(i);
    end
  end

endmodule : tz_count

// File: rtl/bit_index_sequencer.sv
// Serialises a bitmap into a stream of set-bit indices, lowest first.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   din/din_valid     : bitmap word from producer; din_ready accepts it
//   dout/dout_valid   : current lowest set-bit index; dout_ready accepts it
//   dout_last         : dout is the final index of the current word
//   empty             : one-cycle pulse after an all-zero word is accepted
//   busy              : a word is being drained
module bit_index_sequencer
  import bit_index_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          empty,
  output logic                          busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  seq_state_t            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mask_q, w_mask_nxt;
  logic                  r_empty;

  logic [IDX_W:0]        w_tz;
  logic [DATA_WIDTH-1:0] w_mask_rest;   // mask with its lowest set bit cleared
  logic                  w_mask_zero;
  logic                  w_single;
  logic                  w_accept;

  tz_count #(.DATA_WIDTH(DATA_WIDTH)) u_tz_count (
    .i_data  (r_mask_q),
    .o_count (w_tz)
  );

  assign w_mask_rest = r_mask_q & (r_mask_q - DATA_WIDTH'(1));
  assign w_single    = (w_mask_rest == '0);
  assign w_mask_zero = w_tz[IDX_W];

  assign busy       = (r_state == EMIT);
  assign dout_valid = (r_state == EMIT);
  assign dout_last  = (r_state == EMIT) && w_single;
  // Masking on w_mask_zero is defensive only: in EMIT the mask is never zero.
  assign dout       = ((r_state == EMIT) && !w_mask_zero) ? w_tz[IDX_W-1:0] : '0;

  // Ready early on the final beat so the next word loads with no bubble.
  assign din_ready  = (r_state == IDLE) || (dout_last && dout_ready);
  assign w_accept   = din_valid && din_ready;
  assign empty      = r_empty;

  always_comb begin
    w_mask_nxt  = r_mask_q;
    w_state_nxt = r_state;
    if ((r_state == EMIT) && dout_ready) begin
      if (!w_single) begin
        w_mask_nxt = w_mask_rest;
      end else begin
        w_mask_nxt  = '0;
        w_state_nxt = IDLE;
      end
    end
    // A word accepted on the final beat overrides the drain-to-idle above.
    if (w_accept) begin
      if (din != '0) begin
        w_mask_nxt  = din;
        w_state_nxt = EMIT;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mask_q <= '0;
      r_empty  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_mask_q <= w_mask_nxt;
      r_empty  <= w_accept && (din == '0);
    end
  end

endmodule : bit_index_sequencer

// File: tb/tb_bit_index_sequencer.sv
module tb_bit_index_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [2:0]    dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          empty;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  bit_index_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .empty      (empty),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full output beat.
  task automatic beat(input string tag, input logic [2:0] idx, input logic last);
    check({tag, ".valid"}, 32'(dout_valid), 32'd1);
    check({tag, ".dout"},  32'(dout), 32'(idx));
    check({tag, ".last"},  32'(dout_last), 32'(last));
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".valid"}, 32'(dout_valid), 32'd0);
    check({tag, ".dout"},  32'(dout), 32'd0);
    check({tag, ".last"},  32'(dout_last), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".din_ready"}, 32'(din_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    #12;
    idle_chk("reset");
    check("reset.empty", 32'(empty), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Basic drain: A4 -> 2, 5, 7
    din = 8'hA4; din_valid = 1'b1;
    check("basic.ready_idle", 32'(din_ready), 32'd1);
    step();
    din_valid = 1'b0;
    beat("basic.b0", 3'd2, 1'b0);
    check("basic.busy", 32'(busy), 32'd1);
    check("basic.b0_ready", 32'(din_ready), 32'd0);
    step();
    beat("basic.b1", 3'd5, 1'b0);
    step();
    beat("basic.b2", 3'd7, 1'b1);
    check("basic.b2_ready", 32'(din_ready), 32'd1);
    step();
    idle_chk("basic.done");

    // Back-to-back: FF then 01, no bubble
    din = 8'hFF; din_valid = 1'b1;
    step();
    din = 8'h01;
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("b2b.ff%0d", i), 3'(i), (i == 7));
      check($sformatf("b2b.ready%0d", i), 32'(din_ready), 32'(i == 7));
      step();
    end
    beat("b2b.01", 3'd0, 1'b1);
    din_valid = 1'b0;
    step();
    idle_chk("b2b.done");

    // Backpressure: 81 with dout_ready low for 3 cycles
    din = 8'h81; din_valid = 1'b1; dout_ready = 1'b0;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("bp.stall%0d", i), 3'd0, 1'b0);
      check($sformatf("bp.ready%0d", i), 32'(din_ready), 32'd0);
      step();
    end
    dout_ready = 1'b1;
    #1;
    beat("bp.rel0", 3'd0, 1'b0);
    step();
    beat("bp.rel1", 3'd7, 1'b1);
    step();
    idle_chk("bp.done");

    // Zero word: one-cycle empty pulse, no beat
    din = 8'h00; din_valid = 1'b1;
    check("zero.ready", 32'(din_ready), 32'd1);
    step();
    din_valid = 1'b0;
    check("zero.empty", 32'(empty), 32'd1);
    idle_chk("zero.c1");
    step();
    check("zero.empty_off", 32'(empty), 32'd0);
    idle_chk("zero.c2");

    // Single bit: 80 -> one beat index 7
    din = 8'h80; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    beat("single", 3'd7, 1'b1);
    check("single.busy", 32'(busy), 32'd1);
    step();
    idle_chk("single.done");

    // Reset mid-word: F0 -> 4, 5, then async reset
    din = 8'hF0; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    beat("rst.b0", 3'd4, 1'b0);
    step();
    beat("rst.b1", 3'd5, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    idle_chk("rst.async");
    @(negedge clk);
    reset = 1'b0;
    step();
    idle_chk("rst.after");
    din = 8'h02; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    beat("rst.next", 3'd1, 1'b1);
    step();
    idle_chk("rst.done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bit_index_sequencer
